piso_serializer: RTL

Parametrised parallel-in/serial-out converter with a valid/ready load handshake, a one-word holding buffer for gap-free back-to-back frames, selectable bit order and a programmable bit period. It sits between a parallel producer (register file, FSM, FIFO) and a single-wire serial sink. It supersedes the fixed 6-bit, MSB-first, free-running converter. Each frame is WIDTH bits with framing strobes; it emits nothing until a word is handed over.

---
 rtl/piso_serializer_if.sv | 41 ++++
 rtl/piso_serializer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer_if.sv
// Handshake and serial-side signal bundle for piso_serializer.
// The master side is the parallel producer (and serial sink observer); the
// slave side is the serializer itself.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 6
);

  logic [WIDTH-1:0] data_in;
  logic             in_valid;
  logic             in_ready;
  logic             data_out;
  logic             out_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  // Producer view: drives the parallel word, observes everything else.
  modport master (
    output data_in,
    output in_valid,
    input  in_ready,
    input  data_out,
    input  out_valid,
    input  frame_start,
    input  frame_done,
    input  busy
  );

  // Serializer view.
  modport slave (
    input  data_in,
    input  in_valid,
    output in_ready,
    output data_out,
    output out_valid,
    output frame_start,
    output frame_done,
    output busy
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter with a valid/ready load handshake, a
// one-word holding buffer so back-to-back frames leave no idle gap,
// selectable bit order and a programmable bit period (CLKS_PER_BIT).
module piso_serializer #(
  parameter int unsigned WIDTH        = 6,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter logic        IDLE_LEVEL   = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  piso_serializer_if.slave bus
);

  localparam int unsigned BIT_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DIV_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WIDTH - 1);
  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     shreg;
  logic [WIDTH-1:0]     hold;
  logic                 hold_full;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DIV_CNT_W-1:0] div_cnt;

  logic                 data_out_q;
  logic                 out_valid_q;
  logic                 frame_start_q;
  logic                 frame_done_q;
  logic                 busy_q;

  logic                 bit_end;
  logic                 last_cycle;
  logic                 shifter_free;
  logic                 accept;
  logic                 load;
  logic                 hold_fill;
  logic [WIDTH-1:0]     load_word;
  logic [WIDTH-1:0]     shifted;
  logic [BIT_CNT_W-1:0] bit_cnt_nxt;
  logic [DIV_CNT_W-1:0] div_cnt_nxt;
  logic                 shifting_nxt;
  logic                 hold_full_nxt;

  // The bit that goes on the wire first for a given register value.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Load/shift decisions and next counter values for the coming edge.
  always_comb begin
    bit_end       = (div_cnt == DIV_LAST);
    last_cycle    = (state == SHIFT) && (bit_cnt == BIT_LAST) && bit_end;
    shifter_free  = (state == IDLE) || last_cycle;
    accept        = bus.in_valid && !hold_full;
    // The held word always has priority over a fresh one.
    load          = shifter_free && (hold_full || accept);
    hold_fill     = accept && !shifter_free;
    load_word     = hold_full ? hold : bus.data_in;
    shifted       = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

    bit_cnt_nxt   = bit_cnt;
    div_cnt_nxt   = div_cnt;
    shifting_nxt  = 1'b0;
    if (load) begin
      bit_cnt_nxt  = '0;
      div_cnt_nxt  = '0;
      shifting_nxt = 1'b1;
    end else if (shifter_free) begin
      bit_cnt_nxt  = '0;
      div_cnt_nxt  = '0;
      shifting_nxt = 1'b0;
    end else if (bit_end) begin
      bit_cnt_nxt  = bit_cnt + BIT_CNT_W'(1);
      div_cnt_nxt  = '0;
      shifting_nxt = 1'b1;
    end else begin
      div_cnt_nxt  = div_cnt + DIV_CNT_W'(1);
      shifting_nxt = 1'b1;
    end

    hold_full_nxt = hold_full;
    if (hold_fill) begin
      hold_full_nxt = 1'b1;
    end else if (load && hold_full) begin
      hold_full_nxt = 1'b0;
    end
  end

  // Serializer FSM, holding buffer and registered output strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      bit_cnt       <= '0;
      div_cnt       <= '0;
      data_out_q    <= IDLE_LEVEL;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      bit_cnt      <= bit_cnt_nxt;
      div_cnt      <= div_cnt_nxt;
      hold_full    <= hold_full_nxt;
      busy_q       <= shifting_nxt || hold_full_nxt;
      // Pulse lands on the cycle that will carry the final bit period.
      frame_done_q <= shifting_nxt && (bit_cnt_nxt == BIT_LAST) && (div_cnt_nxt == DIV_LAST);

      if (hold_fill) begin
        hold <= bus.data_in;
      end

      case (state)
        IDLE: begin
          if (load) begin
            state         <= SHIFT;
            shreg         <= load_word;
            data_out_q    <= lead_bit(load_word);
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
          end else begin
            data_out_q    <= IDLE_LEVEL;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
          end
        end

        SHIFT: begin
          if (load) begin
            // Gap-free reload on the last bit edge.
            shreg         <= load_word;
            data_out_q    <= lead_bit(load_word);
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
          end else if (last_cycle) begin
            state         <= IDLE;
            data_out_q    <= IDLE_LEVEL;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
          end else begin
            frame_start_q <= 1'b0;
            if (bit_end) begin
              shreg      <= shifted;
              data_out_q <= lead_bit(shifted);
            end
          end
        end

        default: begin
          state         <= IDLE;
          data_out_q    <= IDLE_LEVEL;
          out_valid_q   <= 1'b0;
          frame_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = !hold_full;
  assign bus.data_out    = data_out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = busy_q;

endmodule
